key_loader: RTL and testbench



---
 rtl/key_pkg.sv | 26 ++
 rtl/key_chk_fold.sv | 20 ++
 rtl/key_loader.sv | 154 +++++++++++++++
 tb/tb_key_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types, default widths and the checksum fold for the c432 key loader.
package key_pkg;

    localparam int KEY_W_DEFAULT = 32;
    localparam int CHK_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_KEY,
        SHIFT_CHK,
        CHECK,
        ACTIVE,
        ERROR
    } state_t;

    // XOR of the KEY_W/CHK_W chunks of a default-width key.
    function automatic logic [CHK_W_DEFAULT-1:0] xor_fold(input logic [KEY_W_DEFAULT-1:0] key);
        logic [CHK_W_DEFAULT-1:0] acc;
        acc = '0;
        for (int i = 0; i < KEY_W_DEFAULT / CHK_W_DEFAULT; i++) begin
            acc = acc ^ key[i*CHK_W_DEFAULT +: CHK_W_DEFAULT];
        end
        return acc;
    endfunction

endpackage

// File: rtl/key_chk_fold.sv
// Combinational XOR-fold reducer: folds a KEY_W key into CHK_W bits.
module key_chk_fold
    import key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEFAULT,
    parameter int CHK_W = CHK_W_DEFAULT
) (
    input  logic [KEY_W-1:0] key,
    output logic [CHK_W-1:0] fold
);

    // XOR every CHK_W-wide chunk of the key together.
    always_comb begin
        fold = '0;
        for (int i = 0; i < KEY_W / CHK_W; i++) begin
            fold = fold ^ key[i*CHK_W +: CHK_W];
        end
    end

endmodule

// File: rtl/key_loader.sv
// Serial key loader: shifts in key and checksum LSB first, verifies the
// XOR fold, and exposes the key on key_out only once it has been verified.
module key_loader
    import key_pkg::*;
#(
    parameter int KEY_W   = KEY_W_DEFAULT,
    parameter int CHK_W   = CHK_W_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             clear,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             key_err,
    output logic             busy
);

    localparam int BIT_W  = $clog2(KEY_W + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            next_state;
    logic [KEY_W-1:0]  key_sr;
    logic [CHK_W-1:0]  chk_sr;
    logic [BIT_W-1:0]  bit_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [CHK_W-1:0]  fold;
    logic              beat;
    logic              timeout_hit;
    logic              key_last;
    logic              chk_last;
    logic              busy_d;
    logic              valid_d;
    logic              err_d;
    logic [KEY_W-1:0]  key_d;

    key_chk_fold #(
        .KEY_W (KEY_W),
        .CHK_W (CHK_W)
    ) u_fold (
        .key  (key_sr),
        .fold (fold)
    );

    assign ser_ready   = (state == SHIFT_KEY) || (state == SHIFT_CHK);
    assign beat        = ser_valid && ser_ready;
    // A beat landing on the terminal idle count wins over the timeout.
    assign timeout_hit = ser_ready && !ser_valid && (idle_cnt == IDLE_W'(TIMEOUT));
    assign key_last    = (bit_cnt == BIT_W'(KEY_W - 1));
    assign chk_last    = (bit_cnt == BIT_W'(CHK_W - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; clear outranks load_start, which outranks everything else.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else if (load_start) begin
            next_state = SHIFT_KEY;
        end else begin
            case (state)
                SHIFT_KEY: begin
                    if (beat && key_last) begin
                        next_state = SHIFT_CHK;
                    end else if (timeout_hit) begin
                        next_state = ERROR;
                    end
                end
                SHIFT_CHK: begin
                    if (beat && chk_last) begin
                        next_state = CHECK;
                    end else if (timeout_hit) begin
                        next_state = ERROR;
                    end
                end
                CHECK: begin
                    next_state = (fold == chk_sr) ? ACTIVE : ERROR;
                end
                default: begin
                    next_state = state;
                end
            endcase
        end
    end

    // Output decode: a verdict shows one cycle after entering ACTIVE/ERROR and
    // drops on the same edge the state leaves it.
    always_comb begin
        busy_d  = (next_state == SHIFT_KEY) || (next_state == SHIFT_CHK) ||
                  (next_state == CHECK);
        valid_d = (state == ACTIVE) && (next_state == ACTIVE);
        err_d   = (state == ERROR) && (next_state == ERROR);
        key_d   = valid_d ? key_sr : '0;
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            key_out   <= '0;
        end else begin
            busy      <= busy_d;
            key_valid <= valid_d;
            key_err   <= err_d;
            key_out   <= key_d;
        end
    end

    // Shift registers, bit counter and watchdog; clear and restart wipe them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sr   <= '0;
            chk_sr   <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else if (clear || load_start) begin
            key_sr   <= '0;
            chk_sr   <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else if (beat) begin
            idle_cnt <= '0;
            if (state == SHIFT_KEY) begin
                key_sr <= {ser_data, key_sr[KEY_W-1:1]};
            end else begin
                chk_sr <= {ser_data, chk_sr[CHK_W-1:1]};
            end
            // The counter restarts at zero for the checksum phase.
            if (next_state != state) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end else if (ser_ready && !timeout_hit) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: two instances (watchdog 255 and 4) share the
// stimulus and are compared every cycle against a transaction-level model.
module tb_key_loader;
    import key_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              load_start = 1'b0;
    logic              clear = 1'b0;
    logic              ser_valid = 1'b0;
    logic              ser_data = 1'b0;
    logic [1:0]        rdy;
    logic [1:0]        kv;
    logic [1:0]        ke;
    logic [1:0]        bsy;
    logic [1:0][31:0]  kout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_loader #(.KEY_W(32), .CHK_W(8), .TIMEOUT(255)) dut0 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .clear(clear),
        .ser_valid(ser_valid), .ser_data(ser_data), .ser_ready(rdy[0]),
        .key_out(kout[0]), .key_valid(kv[0]), .key_err(ke[0]), .busy(bsy[0])
    );

    key_loader #(.KEY_W(32), .CHK_W(8), .TIMEOUT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .clear(clear),
        .ser_valid(ser_valid), .ser_data(ser_data), .ser_ready(rdy[1]),
        .key_out(kout[1]), .key_valid(kv[1]), .key_err(ke[1]), .busy(bsy[1])
    );

    // Model: bits received so far, idle run length, and a verdict that becomes
    // visible one cycle after it is reached (verdict: 0 none, 1 good, 2 bad).
    typedef struct {
        bit          coll;
        bit          checking;
        int          nb;
        int          idle;
        logic [39:0] rx;
        int          verdict;
        int          age;
    } mstate_t;

    mstate_t ms [2];
    int      lim [2] = '{255, 4};

    function automatic mstate_t mzero();
        mstate_t z;
        z.coll = 1'b0; z.checking = 1'b0; z.nb = 0; z.idle = 0;
        z.rx = '0; z.verdict = 0; z.age = 0;
        return z;
    endfunction

    function automatic mstate_t step(mstate_t s, int tmo, bit ld, bit clr, bit v, bit d);
        mstate_t r;
        r = s;
        if (clr) begin
            r = mzero();
        end else if (ld) begin
            r = mzero();
            r.coll = 1'b1;
        end else if (s.coll) begin
            if (v) begin
                r.rx[s.nb] = d;
                r.nb = s.nb + 1;
                r.idle = 0;
                if (r.nb == 40) begin
                    r.coll = 1'b0;
                    r.checking = 1'b1;
                end
            end else if (s.idle == tmo) begin
                r.coll = 1'b0;
                r.verdict = 2;
                r.age = 0;
            end else begin
                r.idle = s.idle + 1;
            end
        end else if (s.checking) begin
            r.checking = 1'b0;
            r.verdict = (xor_fold(s.rx[31:0]) == s.rx[39:32]) ? 1 : 2;
            r.age = 0;
        end else if (s.verdict != 0 && s.age < 2) begin
            r.age = s.age + 1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) ms[m] <= mzero();
            else        ms[m] <= step(ms[m], lim[m], load_start, clear, ser_valid, ser_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic        ev;
            logic        ee;
            logic [31:0] ek;
            ev = (ms[m].verdict == 1) && (ms[m].age >= 1);
            ee = (ms[m].verdict == 2) && (ms[m].age >= 1);
            ek = ev ? ms[m].rx[31:0] : 32'h0;
            check($sformatf("m%0d.ser_ready", m), 32'(rdy[m]), 32'(ms[m].coll));
            check($sformatf("m%0d.busy", m), 32'(bsy[m]), 32'(ms[m].coll || ms[m].checking));
            check($sformatf("m%0d.key_valid", m), 32'(kv[m]), 32'(ev));
            check($sformatf("m%0d.key_err", m), 32'(ke[m]), 32'(ee));
            check($sformatf("m%0d.key_out", m), kout[m], ek);
        end
    end

    task automatic pulse_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic send_bits(input logic [39:0] w, input int nbits, input int gap, output int rcnt);
        rcnt = 0;
        for (int i = 0; i < nbits; i++) begin
            ser_valid = 1'b1;
            ser_data  = w[i];
            if (rdy[0]) rcnt++;
            @(negedge clk);
            ser_valid = 1'b0;
            if (i != nbits - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_stream(input logic [31:0] key, input logic [7:0] chk, input int gap);
        int rc;
        send_bits({chk, key}, 40, gap, rc);
    endtask

    initial begin
        int rc;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.key_out", kout[0], 32'h0);
        check("rst.key_valid", 32'(kv[0]), 32'h0);
        check("rst.key_err", 32'(ke[0]), 32'h0);
        check("rst.busy", 32'(bsy[0]), 32'h0);
        check("rst.ser_ready", 32'(rdy[0]), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pin the model's fold against hand-computed values.
        check("fold.12345678", 32'(xor_fold(32'h12345678)), 32'h08);
        check("fold.A5A50F0F", 32'(xor_fold(32'hA5A50F0F)), 32'h00);

        // Nominal load with ser_valid held high.
        pulse_load();
        send_bits({8'h08, 32'h12345678}, 40, 0, rc);
        check("nom.ready_cycles", 32'(rc), 32'd40);
        check("nom.busy_in_check", 32'(bsy[0]), 32'h1);
        @(negedge clk);
        check("nom.kv_one_edge", 32'(kv[0]), 32'h0);
        @(negedge clk);
        check("nom.kv", 32'(kv[0]), 32'h1);
        check("nom.key", kout[0], 32'h12345678);
        check("nom.err", 32'(ke[0]), 32'h0);

        // Bad checksum: sticky error until load_start.
        pulse_load();
        send_stream(32'h12345678, 8'h09, 0);
        repeat (2) @(negedge clk);
        check("bad.err", 32'(ke[0]), 32'h1);
        check("bad.kv", 32'(kv[0]), 32'h0);
        check("bad.key", kout[0], 32'h0);
        repeat (20) @(negedge clk);
        check("bad.err_sticky", 32'(ke[0]), 32'h1);
        pulse_load();
        check("bad.err_dropped", 32'(ke[0]), 32'h0);
        pulse_clear();

        // 10-cycle gaps: fine with watchdog 255, timeout with watchdog 4.
        pulse_load();
        send_stream(32'h12345678, 8'h08, 10);
        repeat (2) @(negedge clk);
        check("gap10.kv", 32'(kv[0]), 32'h1);
        check("gap10.key", kout[0], 32'h12345678);
        check("gap10.t4_err", 32'(ke[1]), 32'h1);
        check("gap10.t4_key", kout[1], 32'h0);
        pulse_clear();

        // Gap exactly at the watchdog limit is tolerated.
        pulse_load();
        send_stream(32'h12345678, 8'h08, 4);
        repeat (2) @(negedge clk);
        check("gap4.t4_kv", 32'(kv[1]), 32'h1);
        check("gap4.t4_key", kout[1], 32'h12345678);
        pulse_clear();

        // One cycle beyond the limit times out.
        pulse_load();
        send_stream(32'h12345678, 8'h08, 5);
        repeat (2) @(negedge clk);
        check("gap5.t4_err", 32'(ke[1]), 32'h1);
        check("gap5.t4_key", kout[1], 32'h0);
        check("gap5.t255_kv", 32'(kv[0]), 32'h1);
        pulse_clear();

        // Restart after 17 key bits.
        pulse_load();
        send_bits(40'hFF_FFFF_FFFF, 17, 0, rc);
        pulse_load();
        send_stream(32'hA5A50F0F, 8'h00, 0);
        repeat (2) @(negedge clk);
        check("restart.kv", 32'(kv[0]), 32'h1);
        check("restart.key", kout[0], 32'hA5A50F0F);

        // clear together with load_start in ACTIVE: clear wins.
        clear = 1'b1;
        load_start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        load_start = 1'b0;
        check("prio.key", kout[0], 32'h0);
        check("prio.kv", 32'(kv[0]), 32'h0);
        check("prio.busy", 32'(bsy[0]), 32'h0);
        check("prio.ready", 32'(rdy[0]), 32'h0);

        // Asynchronous reset in the middle of the checksum phase.
        pulse_load();
        send_bits({8'h08, 32'h12345678}, 35, 0, rc);
        #2 rst_n = 1'b0;
        #1;
        check("areset.ready", 32'(rdy[0]), 32'h0);
        check("areset.busy", 32'(bsy[0]), 32'h0);
        check("areset.key", kout[0], 32'h0);
        check("areset.kv", 32'(kv[0] | ke[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_load();
        send_stream(32'h12345678, 8'h08, 0);
        repeat (2) @(negedge clk);
        check("post_reset.kv", 32'(kv[0]), 32'h1);
        check("post_reset.key", kout[0], 32'h12345678);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
